// File: rtl/fetch_unit_if.sv
// Fetch-unit boundary: instruction-memory request/response, execute redirect and decode handshake.
// "master" is the fetch unit's view; "slave" is the view of the surrounding memory/pipeline.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_inst, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_inst, out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: credit-limited in-order requests to a variable-latency
// memory, a DEPTH-entry {pc, inst} queue to decode, and redirect flush with stale-response drop.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic [31:0] fetch_pc;
    logic [31:0] rsp_pc;
    cnt_t        inflight;
    cnt_t        drop_cnt;
    cnt_t        count;
    ptr_t        rd_ptr;
    ptr_t        wr_ptr;
    entry_t      queue_mem [DEPTH];

    logic        credit_ok;
    logic        req_valid;
    logic        req_fire;
    logic        head_valid;
    logic        pop;
    logic        push;
    logic [31:0] redirect_tgt;
    cnt_t        inflight_after_rsp;

    // NOTE: every signal assigned in this block gets a value on every path, so no latch is inferred.
    always_comb begin
        // Slots already promised to outstanding requests count against the queue.
        credit_ok          = ({1'b0, inflight} + {1'b0, count}) < (CNT_W + 1)'(DEPTH);
        req_valid          = rst & ~bus.redirect_valid & credit_ok;
        req_fire           = req_valid & bus.imem_req_ready;
        head_valid         = (count != '0) & ~bus.redirect_valid;
        pop                = head_valid & bus.out_ready;
        push               = bus.imem_rsp_valid & (drop_cnt == '0) & ~bus.redirect_valid;
        redirect_tgt       = bus.redirect_pc & 32'hFFFF_FFFC;
        inflight_after_rsp = inflight - cnt_t'(bus.imem_rsp_valid);
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.out_valid      = head_valid;
    assign bus.out_inst       = queue_mem[rd_ptr].inst;
    assign bus.out_pc         = queue_mem[rd_ptr].pc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            // NOTE: the queue storage is reset because the head entry drives out_pc/out_inst directly.
            for (int i = 0; i < DEPTH; i++) begin
                queue_mem[i] <= '{pc: RESET_PC, inst: 32'h0};
            end
        end else begin
            inflight <= inflight_after_rsp + cnt_t'(req_fire);
            if (bus.redirect_valid) begin
                // Whatever is still outstanding after this cycle belongs to the old path.
                fetch_pc <= redirect_tgt;
                rsp_pc   <= redirect_tgt;
                drop_cnt <= inflight_after_rsp;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (bus.imem_rsp_valid && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - cnt_t'(1);
                end
                if (push) begin
                    queue_mem[wr_ptr] <= '{pc: rsp_pc, inst: bus.imem_rsp_data};
                    wr_ptr            <= wr_ptr + ptr_t'(1);
                    rsp_pc            <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ptr_t'(1);
                end
                count <= count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table and corner sequences plus randomized
// traffic compared against a queue-based reference model and an in-order memory model.
module tb_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic        rr;
        logic        ordy;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_ov;
        logic [31:0] exp_pc;
    } vec_t;

    int n_checks;
    int n_errors;
    int cyc;
    int mem_lat;
    int rsp_pct;

    pend_t pend[$];
    ent_t  mq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_rsp_pc;
    int          m_inflight;
    int          m_drop;

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_out_valid;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_inst;

    vec_t tbl [9];

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, want %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: compares this cycle's outputs, then applies the cycle's events.
    task automatic model_step(input logic rr, input logic ordy, input logic redir,
                              input logic [31:0] rpc, input logic rv, input logic [31:0] rd);
        logic exp_rv;
        logic exp_ov;
        exp_rv = !redir && (m_inflight + mq.size() < DEPTH);
        exp_ov = (mq.size() != 0) && !redir;
        check_bit("m_req_valid", s_req_valid, exp_rv);
        if (exp_rv) check("m_req_addr", s_req_addr, m_fetch_pc);
        check_bit("m_out_valid", s_out_valid, exp_ov);
        if (exp_ov) begin
            check("m_out_pc", s_out_pc, mq[0].pc);
            check("m_out_inst", s_out_inst, mq[0].inst);
        end
        if (rv) begin
            check_bit("m_rsp_has_req", m_inflight > 0, 1'b1);
            if (m_inflight > 0) m_inflight--;
            if (m_drop > 0) begin
                m_drop--;
            end else if (!redir) begin
                check_bit("m_push_not_full", mq.size() < DEPTH, 1'b1);
                mq.push_back('{pc: m_rsp_pc, inst: rd});
                m_rsp_pc += 32'd4;
            end
        end
        if (exp_rv && rr) begin
            m_fetch_pc += 32'd4;
            m_inflight++;
        end
        if (redir) begin
            mq.delete();
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
            m_rsp_pc   = m_fetch_pc;
            m_drop     = m_inflight;
        end else if (exp_ov && ordy) begin
            void'(mq.pop_front());
        end
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, update models.
    task automatic cycle(input logic rr, input logic ordy, input logic redir, input logic [31:0] rpc);
        logic        rv;
        logic [31:0] rd;
        @(negedge clk);
        rst = 1'b1;
        rv  = 1'b0;
        rd  = 32'h0;
        if (pend.size() != 0 && pend[0].due <= cyc && int'($urandom_range(99)) < rsp_pct) begin
            rv = 1'b1;
            rd = inst_of(pend[0].addr);
            void'(pend.pop_front());
        end
        bus.imem_req_ready = rr;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rd;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.out_ready      = ordy;
        #1;
        s_req_valid = bus.imem_req_valid;
        s_req_addr  = bus.imem_req_addr;
        s_out_valid = bus.out_valid;
        s_out_pc    = bus.out_pc;
        s_out_inst  = bus.out_inst;
        model_step(rr, ordy, redir, rpc, rv, rd);
        if (s_req_valid && rr) pend.push_back('{addr: s_req_addr, due: cyc + mem_lat});
        cyc++;
    endtask

    // Asynchronous reset: outputs must settle to reset values without a clock edge.
    task automatic do_reset();
        rst                = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        #1;
        check_bit("rst_req_valid", bus.imem_req_valid, 1'b0);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_inst", bus.out_inst, 32'h0);
        check("rst_out_pc", bus.out_pc, RESET_PC);
        m_fetch_pc = RESET_PC;
        m_rsp_pc   = RESET_PC;
        m_inflight = 0;
        m_drop     = 0;
        mq.delete();
        pend.delete();
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        mem_lat  = 1;
        rsp_pct  = 100;

        // Decode stalled after reset: credit stops requests at four, one pop frees one slot.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0000};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0004};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004};

        do_reset();

        // Streaming from reset with 1-cycle memory and decode always ready.
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            check_bit("s1_req_valid", s_req_valid, 1'b1);
            check("s1_req_addr", s_req_addr, 32'(4 * k));
            if (k >= 2) begin
                check_bit("s1_out_valid", s_out_valid, 1'b1);
                check("s1_out_pc", s_out_pc, 32'(4 * (k - 2)));
                check("s1_out_inst", s_out_inst, inst_of(32'(4 * (k - 2))));
            end else begin
                check_bit("s1_out_valid", s_out_valid, 1'b0);
            end
        end

        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].rr, tbl[i].ordy, 1'b0, 32'h0);
            check_bit("tbl_req_valid", s_req_valid, tbl[i].exp_rv);
            if (tbl[i].exp_rv) check("tbl_req_addr", s_req_addr, tbl[i].exp_addr);
            check_bit("tbl_out_valid", s_out_valid, tbl[i].exp_ov);
            if (tbl[i].exp_ov) begin
                check("tbl_out_pc", s_out_pc, tbl[i].exp_pc);
                check("tbl_out_inst", s_out_inst, inst_of(tbl[i].exp_pc));
            end
        end

        // Three requests in flight, then redirect to an unaligned target.
        mem_lat = 4;
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0010);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            check("s3_req_addr", s_req_addr, 32'h10 + 32'(4 * k));
        end
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        check_bit("s3_redir_req_valid", s_req_valid, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_bit("s3_resume_req_valid", s_req_valid, 1'b1);
        check("s3_resume_addr", s_req_addr, 32'h0000_0100);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_out_valid) found = 1'b1;
        end
        check_bit("s3_first_out_seen", found, 1'b1);
        if (found) check("s3_first_out_pc", s_out_pc, 32'h0000_0100);

        // Redirect coinciding with a response and out_ready while two entries are queued.
        do_reset();
        mem_lat = 1;
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0040);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        check_bit("s4_redir_out_valid", s_out_valid, 1'b0);
        check_bit("s4_redir_req_valid", s_req_valid, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_bit("s4_empty_after_redir", s_out_valid, 1'b0);
        check("s4_resume_addr", s_req_addr, 32'h0000_0300);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_bit("s4_first_out_valid", s_out_valid, 1'b1);
        check("s4_first_out_pc", s_out_pc, 32'h0000_0300);

        // Address wrap at the top of the 32-bit space.
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (k < 3) check("s5_req_addr", s_req_addr, 32'hFFFF_FFF8 + 32'(4 * k));
            if (k >= 2) begin
                check_bit("s5_out_valid", s_out_valid, 1'b1);
                check("s5_out_pc", s_out_pc, 32'hFFFF_FFF8 + 32'(4 * (k - 2)));
            end
        end

        // Mid-stream asynchronous reset with three entries queued.
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("s6_pre_out_valid", s_out_valid, 1'b1);
        check("s6_pre_out_pc", s_out_pc, 32'h0000_0200);
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("s6_restart_addr", s_req_addr, RESET_PC);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("s6_restart_out_pc", s_out_pc, RESET_PC);

        // Randomized traffic across latencies, response stalls, redirects and one reset.
        for (int r = 0; r < 6; r++) begin
            mem_lat = 1 + r;
            rsp_pct = (r % 2 == 1) ? 60 : 100;
            if (r == 3) do_reset();
            for (int n = 0; n < 400; n++) begin
                cycle($urandom_range(99) < 80, $urandom_range(99) < 70,
                      $urandom_range(99) < 5, $urandom());
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
